// File: rtl/sonic_cmd_rx.sv
// rtl/sonic_cmd_rx.sv - PCIe MWr command mailbox receiver
// Decodes host mailbox writes, merges one beat bytewise and raises cmd_valid until acked.
module sonic_cmd_rx #(
  parameter int          BAR_IDX     = 0,
  parameter logic [31:0] MAILBOX_OFS = 32'h0000_0100,
  parameter int          OFS_WIDTH   = 12
) (
  input  logic         clk_in,
  input  logic         reset,
  input  logic         init,
  input  logic         rx_req,
  input  logic [135:0] rx_desc,
  output logic         rx_ack,
  output logic         rx_abort,
  input  logic         rx_dfr,
  input  logic         rx_dv,
  input  logic [127:0] rx_data,
  input  logic [15:0]  rx_be,
  output logic         rx_ws,
  output logic [127:0] mailbox,
  output logic         cmd_valid,
  input  logic         cmd_ack,
  output logic [15:0]  cmd_cnt,
  output logic [15:0]  drop_cnt
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_ACK    = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_COMMIT = 3'd3;
  localparam logic [2:0] S_DROP   = 3'd4;

  logic [2:0]   state_q, state_d;
  logic         accept_q, accept_d;
  logic [1:0]   idx_q, idx_d;
  logic [2:0]   span_q, span_d;
  logic [127:0] mailbox_q, mailbox_d;
  logic         cmd_valid_q, cmd_valid_d;
  logic [15:0]  cmd_cnt_q, cmd_cnt_d;
  logic [15:0]  drop_cnt_q, drop_cnt_d;

  logic [63:0]  in_addr;
  logic [9:0]   in_len;
  logic [1:0]   in_idx;
  logic [2:0]   in_span;
  logic         in_accept;
  logic [3:0]   dw_en;
  logic [15:0]  byte_wr;
  logic         take;
  logic         drop_inc;
  logic         commit_set;
  logic         unused_desc;

  // Descriptor is decoded as it arrives so only the verdict and DW window are held.
  assign in_addr = rx_desc[125] ? rx_desc[63:0] : {32'h0, rx_desc[63:32]};
  assign in_len  = rx_desc[105:96];
  assign in_idx  = in_addr[3:2];
  assign in_span = {1'b0, in_idx} + in_len[2:0];
  assign in_accept = rx_desc[128+BAR_IDX] && rx_desc[126] && (rx_desc[124:120] == 5'b00000) &&
                     (in_addr[OFS_WIDTH-1:4] == MAILBOX_OFS[OFS_WIDTH-1:4]) &&
                     (in_len != 10'd0) && (in_len <= 10'd4) && (in_span <= 3'd4);
  assign unused_desc = ^{rx_desc, in_addr};

  assign rx_ws    = (state_q == S_DATA) && cmd_valid_q && !cmd_ack;
  assign take     = (state_q == S_DATA) && rx_dv && !rx_ws;
  assign rx_ack   = (state_q == S_ACK);
  assign rx_abort = 1'b0;

  always_comb begin
    dw_en = 4'b0000;
    for (int i = 0; i < 4; i++) begin
      dw_en[i] = (3'(i) >= {1'b0, idx_q}) && (3'(i) < span_q);
    end
    byte_wr = 16'h0000;
    for (int b = 0; b < 16; b++) begin
      byte_wr[b] = dw_en[b/4] && rx_be[b];
    end
  end

  always_comb begin
    state_d    = state_q;
    accept_d   = accept_q;
    idx_d      = idx_q;
    span_d     = span_q;
    mailbox_d  = mailbox_q;
    drop_inc   = 1'b0;
    commit_set = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (rx_req) begin
          accept_d = in_accept;
          idx_d    = in_idx;
          span_d   = in_span;
          state_d  = S_ACK;
        end
      end
      S_ACK: begin
        if (accept_q) begin
          state_d = S_DATA;
        end else if (rx_dfr) begin
          state_d = S_DROP;
        end else begin
          drop_inc = 1'b1;
          state_d  = S_IDLE;
        end
      end
      S_DATA: begin
        if (take) begin
          for (int b = 0; b < 16; b++) begin
            if (byte_wr[b]) mailbox_d[8*b +: 8] = rx_data[8*b +: 8];
          end
          state_d = S_COMMIT;
        end
      end
      S_COMMIT: begin
        // Accepted windows always start at idx_q, so DW0 is covered exactly when idx_q is 0.
        commit_set = (idx_q == 2'd0);
        state_d    = S_IDLE;
      end
      S_DROP: begin
        if (!rx_dfr && !rx_dv) begin
          drop_inc = 1'b1;
          state_d  = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    cmd_valid_d = commit_set || (cmd_valid_q && !cmd_ack);
    cmd_cnt_d   = cmd_cnt_q + {15'b0, commit_set};
    drop_cnt_d  = (drop_inc && (drop_cnt_q != 16'hFFFF)) ? drop_cnt_q + 16'd1 : drop_cnt_q;
  end

  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      accept_q    <= 1'b0;
      idx_q       <= 2'd0;
      span_q      <= 3'd0;
      mailbox_q   <= '0;
      cmd_valid_q <= 1'b0;
      cmd_cnt_q   <= '0;
      drop_cnt_q  <= '0;
    end else if (init) begin
      state_q     <= S_IDLE;
      accept_q    <= 1'b0;
      idx_q       <= 2'd0;
      span_q      <= 3'd0;
      mailbox_q   <= '0;
      cmd_valid_q <= 1'b0;
      cmd_cnt_q   <= '0;
      drop_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      accept_q    <= accept_d;
      idx_q       <= idx_d;
      span_q      <= span_d;
      mailbox_q   <= mailbox_d;
      cmd_valid_q <= cmd_valid_d;
      cmd_cnt_q   <= cmd_cnt_d;
      drop_cnt_q  <= drop_cnt_d;
    end
  end

  assign mailbox   = mailbox_q;
  assign cmd_valid = cmd_valid_q;
  assign cmd_cnt   = cmd_cnt_q;
  assign drop_cnt  = drop_cnt_q;

endmodule

// File: tb/tb_sonic_cmd_rx.sv
// tb/tb_sonic_cmd_rx.sv - directed bench for sonic_cmd_rx
// Transaction-level mailbox model with a per-cycle output compare.
module tb_sonic_cmd_rx;

  logic         clk_in = 1'b0;
  logic         reset = 1'b1;
  logic         init = 1'b0;
  logic         rx_req = 1'b0;
  logic [135:0] rx_desc = '0;
  logic         rx_ack;
  logic         rx_abort;
  logic         rx_dfr = 1'b0;
  logic         rx_dv = 1'b0;
  logic [127:0] rx_data = '0;
  logic [15:0]  rx_be = '0;
  logic         rx_ws;
  logic [127:0] mailbox;
  logic         cmd_valid;
  logic         cmd_ack = 1'b0;
  logic [15:0]  cmd_cnt;
  logic [15:0]  drop_cnt;

  sonic_cmd_rx dut (
    .clk_in(clk_in), .reset(reset), .init(init),
    .rx_req(rx_req), .rx_desc(rx_desc), .rx_ack(rx_ack), .rx_abort(rx_abort),
    .rx_dfr(rx_dfr), .rx_dv(rx_dv), .rx_data(rx_data), .rx_be(rx_be), .rx_ws(rx_ws),
    .mailbox(mailbox), .cmd_valid(cmd_valid), .cmd_ack(cmd_ack),
    .cmd_cnt(cmd_cnt), .drop_cnt(drop_cnt)
  );

  always #5 clk_in = ~clk_in;

  int total = 0;
  int bad = 0;
  bit chk_en = 1'b0;

  logic [127:0] exp_mb = '0;
  logic         exp_cv = 1'b0;
  logic [15:0]  exp_cnt = '0;
  logic [15:0]  exp_drop = '0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%h exp=%h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] m_addr(input logic [135:0] d);
    return d[125] ? d[63:0] : {32'h0, d[63:32]};
  endfunction

  function automatic bit model_accept(input logic [135:0] d);
    logic [63:0] a;
    int len;
    int idx;
    a = m_addr(d);
    len = int'(d[105:96]);
    idx = int'(a[3:2]);
    return d[128] && d[126] && (d[124:120] == 5'd0) && (a[11:4] == 8'h10) &&
           (len >= 1) && (len <= 4) && (idx + len <= 4);
  endfunction

  function automatic logic [127:0] model_merge(input logic [127:0] mb, input logic [127:0] data,
                                               input logic [15:0] be, input int idx, input int len);
    logic [127:0] r;
    r = mb;
    for (int b = 0; b < 16; b++) begin
      if ((b / 4) >= idx && (b / 4) < idx + len && be[b]) r[8*b +: 8] = data[8*b +: 8];
    end
    return r;
  endfunction

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  function automatic logic [135:0] mk(input logic [7:0] bar, input logic [1:0] fmt, input logic [4:0] typ,
                                      input logic [9:0] len, input logic [63:0] addr);
    logic [135:0] d;
    d = '0;
    d[135:128] = bar;
    d[126:125] = fmt;
    d[124:120] = typ;
    d[105:96]  = len;
    d[71:64]   = 8'hFF;
    if (fmt[0]) d[63:0] = addr;
    else        d[63:32] = addr[31:0];
    return d;
  endfunction

  always @(negedge clk_in) begin
    if (chk_en) begin
      chk("mailbox", mailbox, exp_mb);
      chk("cmd_valid", {127'b0, cmd_valid}, {127'b0, exp_cv});
      chk("cmd_cnt", {112'b0, cmd_cnt}, {112'b0, exp_cnt});
      chk("drop_cnt", {112'b0, drop_cnt}, {112'b0, exp_drop});
    end
  end

  task automatic ack_cmd();
    @(posedge clk_in); #1; cmd_ack = 1'b1;
    @(posedge clk_in); #1; cmd_ack = 1'b0; exp_cv = 1'b0;
  endtask

  task automatic do_tlp(input logic [135:0] desc, input logic [127:0] data, input logic [15:0] be,
                        input int nbeats, input int ack_delay, input bit ack_commit);
    bit acc;
    bit taken;
    int idx;
    int len;
    acc = model_accept(desc);
    idx = int'(m_addr(desc) & 64'hC) / 4;
    len = int'(desc[105:96]);
    @(posedge clk_in); #1;
    rx_req = 1'b1; rx_desc = desc; rx_dfr = (nbeats > 0);
    @(posedge clk_in); #1;
    rx_req = 1'b0;
    @(negedge clk_in);
    chk("rx_ack_pulse", {127'b0, rx_ack}, 128'd1);
    @(posedge clk_in); #1;
    if (acc) begin
      rx_dv = 1'b1; rx_data = data; rx_be = be; taken = 1'b0;
      for (int i = 0; i < 40; i++) begin
        @(negedge clk_in);
        chk("rx_ack_low", {127'b0, rx_ack}, 128'd0);
        chk("rx_ws", {127'b0, rx_ws}, {127'b0, exp_cv && !cmd_ack});
        if (!(exp_cv && !cmd_ack)) begin
          taken = 1'b1;
          break;
        end
        @(posedge clk_in); #1;
        if (i + 1 == ack_delay) cmd_ack = 1'b1;
      end
      if (!taken) begin
        total++; bad++;
        $display("FAIL ws_timeout act=stalled exp=beat_taken");
      end
      @(posedge clk_in); #1;
      if (cmd_ack) exp_cv = 1'b0;
      rx_dv = 1'b0; rx_dfr = 1'b0; cmd_ack = ack_commit;
      exp_mb = model_merge(exp_mb, data, be, idx, len);
      @(posedge clk_in); #1;
      cmd_ack = 1'b0;
      if (idx == 0) begin
        exp_cv = 1'b1;
        exp_cnt = exp_cnt + 16'd1;
      end else if (ack_commit) begin
        exp_cv = 1'b0;
      end
    end else if (nbeats == 0) begin
      exp_drop = sat_inc(exp_drop);
    end else begin
      for (int b = 0; b < nbeats; b++) begin
        rx_dv = 1'b1; rx_data = data; rx_be = be;
        @(negedge clk_in);
        chk("rx_ws_drop", {127'b0, rx_ws}, 128'd0);
        @(posedge clk_in); #1;
      end
      rx_dv = 1'b0; rx_dfr = 1'b0;
      @(posedge clk_in); #1;
      exp_drop = sat_inc(exp_drop);
    end
  endtask

  localparam logic [127:0] D1 = 128'hDEADBEEF_CAFEF00D_12345678_00000001;
  localparam logic [127:0] D2 = 128'h11111111_22222222_33333333_44444444;
  localparam logic [127:0] D4 = 128'h0F0E0D0C_0B0A0908_07060504_03020100;

  initial begin
    #200000;
    $display("FAIL watchdog act=running exp=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [135:0] d_t1;
    logic [135:0] d_bad;
    d_t1  = mk(8'h01, 2'b11, 5'd0, 10'd4, 64'h1_0000_0100);
    d_bad = mk(8'h01, 2'b11, 5'd0, 10'd1, 64'h0000_0200);

    repeat (2) @(posedge clk_in);
    #1; reset = 1'b0;
    @(negedge clk_in);
    chk("rst_mailbox", mailbox, 128'd0);
    chk("rst_flags", {124'b0, rx_ack, rx_ws, rx_abort, cmd_valid}, 128'd0);
    chk("rst_counts", {96'b0, cmd_cnt, drop_cnt}, 128'd0);
    chk("model_pin_acc", {127'b0, model_accept(d_t1)}, 128'd1);
    chk("model_pin_drop", {127'b0, model_accept(d_bad)}, 128'd0);
    chk_en = 1'b1;

    do_tlp(d_t1, D1, 16'hFFFF, 1, 0, 1'b0);
    chk("t1_mailbox", mailbox, D1);
    chk("t1_cnt", {112'b0, cmd_cnt}, 128'd1);
    ack_cmd();

    do_tlp(mk(8'h01, 2'b10, 5'd0, 10'd2, 64'h108), D2, 16'hFFFF, 1, 0, 1'b0);
    chk("t2_mailbox", mailbox, {64'h11111111_22222222, 64'h12345678_00000001});
    chk("t2_cv", {127'b0, cmd_valid}, 128'd0);

    do_tlp(d_t1, 128'h55555555_66666666_77777777_88888888, 16'hFFFF, 1, 0, 1'b0);
    do_tlp(d_t1, D4, 16'hFFFF, 1, 3, 1'b0);
    chk("t3_mailbox", mailbox, D4);
    chk("t3_cnt", {112'b0, cmd_cnt}, 128'd3);

    do_tlp(d_bad, 128'h99, 16'hFFFF, 1, 0, 1'b0);
    do_tlp(mk(8'h01, 2'b01, 5'd0, 10'd1, 64'h100), 128'h0, 16'h0, 0, 0, 1'b0);
    do_tlp(mk(8'h01, 2'b11, 5'd0, 10'd8, 64'h100), 128'h77, 16'hFFFF, 2, 0, 1'b0);
    do_tlp(mk(8'h01, 2'b11, 5'd0, 10'd0, 64'h100), 128'h66, 16'hFFFF, 1, 0, 1'b0);
    do_tlp(mk(8'h01, 2'b10, 5'd0, 10'd2, 64'h10C), 128'h55, 16'hFFFF, 1, 0, 1'b0);
    do_tlp(mk(8'h02, 2'b11, 5'd0, 10'd4, 64'h100), 128'h44, 16'hFFFF, 1, 0, 1'b0);
    chk("drops_mailbox", mailbox, D4);
    chk("drops_cnt", {112'b0, drop_cnt}, 128'd6);
    ack_cmd();

    do_tlp(mk(8'h01, 2'b10, 5'd0, 10'd1, 64'h104), 128'hFFFFFFFF_FFFFFFFF_BBBBBBBB_FFFFFFFF,
           16'hFFFF, 1, 0, 1'b0);
    do_tlp(mk(8'h01, 2'b11, 5'd0, 10'd1, 64'h100), 128'hAAAAAAAA_AAAAAAAA_AAAAAAAA_00000007,
           16'h000F, 1, 0, 1'b1);
    chk("t5_mailbox", mailbox, 128'h0F0E0D0C_0B0A0908_BBBBBBBB_00000007);
    chk("t5_cv_setwins", {127'b0, cmd_valid}, 128'd1);
    chk("t5_cnt", {112'b0, cmd_cnt}, 128'd4);

    @(posedge clk_in); #1;
    rx_req = 1'b1; rx_desc = d_bad; rx_dfr = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk_in);
      chk("b2b_ack", {127'b0, rx_ack}, {127'b0, 1'(i % 2)});
      @(posedge clk_in); #1;
      if (i % 2 == 1) exp_drop = sat_inc(exp_drop);
    end
    rx_req = 1'b0;
    chk("b2b_drops", {112'b0, drop_cnt}, 128'd9);

    @(posedge clk_in); #1;
    force dut.drop_cnt_q = 16'hFFFF;
    exp_drop = 16'hFFFF;
    @(posedge clk_in); #1;
    release dut.drop_cnt_q;
    do_tlp(d_bad, 128'h0, 16'h0, 0, 0, 1'b0);
    chk("drop_sat", {112'b0, drop_cnt}, 128'h0000FFFF);

    ack_cmd();
    @(posedge clk_in); #1;
    rx_req = 1'b1; rx_desc = d_t1; rx_dfr = 1'b1;
    @(posedge clk_in); #1;
    rx_req = 1'b0;
    @(posedge clk_in); #2;
    reset = 1'b1;
    exp_mb = '0; exp_cv = 1'b0; exp_cnt = '0; exp_drop = '0;
    #1;
    chk("midrst_mailbox", mailbox, 128'd0);
    chk("midrst_flags", {124'b0, rx_ack, rx_ws, rx_abort, cmd_valid}, 128'd0);
    chk("midrst_counts", {96'b0, cmd_cnt, drop_cnt}, 128'd0);
    @(posedge clk_in); #1;
    reset = 1'b0; rx_dfr = 1'b0;
    do_tlp(d_t1, D1, 16'hFFFF, 1, 0, 1'b0);
    chk("post_rst_mailbox", mailbox, D1);
    chk("post_rst_cnt", {112'b0, cmd_cnt}, 128'd1);

    do_tlp(d_bad, 128'h0, 16'h0, 0, 0, 1'b0);
    @(posedge clk_in); #1;
    init = 1'b1;
    @(posedge clk_in); #1;
    init = 1'b0;
    exp_mb = '0; exp_cv = 1'b0; exp_cnt = '0; exp_drop = '0;
    @(negedge clk_in);
    chk("init_mailbox", mailbox, 128'd0);
    chk("init_counts", {95'b0, cmd_valid, cmd_cnt, drop_cnt}, 128'd0);

    @(posedge clk_in); #1;
    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sonic_cmd_rx.md
Name: sonic_cmd_rx

Overview:
- PCIe backend receive-side target for host-issued command mailbox writes.
- Host software posts a 1–4 DW memory write (MWr) TLP into a 128-bit mailbox in a selected BAR. The block decodes the descriptor, merges the data bytewise into the mailbox, and raises a command-valid level to the command engine until acknowledged.
- It is the inbound counterpart of the RC update writer, which reports cmd_response/cmd_error_code back to host memory.

Parameters:
- BAR_IDX, 0, rx_desc[135:128] BAR-hit bit that selects this block.
- MAILBOX_OFS, 32'h0000_0100, byte offset of the mailbox in the BAR; bits [3:0] are ignored.
- OFS_WIDTH, 12, number of low address bits compared against MAILBOX_OFS.

Ports:
- clk_in, in, 1, clock.
- reset, in, 1, asynchronous, active-high reset.
- init, in, 1, synchronous clear of the mailbox, counters and FSM.
- rx_req, in, 1, descriptor valid from the PCIe backend.
- rx_desc, in, 136, [135:128] BAR hit, [126:125] fmt, [124:120] type, [105:96] length in DW, [71:68] lbe, [67:64] fbe, [63:0] address. 3DW headers carry the address in [63:32].
- rx_ack, out, 1, descriptor accept pulse.
- rx_abort, out, 1, tied 0.
- rx_dfr, in, 1, data phase pending.
- rx_dv, in, 1, data beat valid.
- rx_data, in, 128, payload. DW0 is [31:0] and sits at the 16-byte-aligned mailbox base.
- rx_be, in, 16, per-byte enables of the beat.
- rx_ws, out, 1, wait state; stalls the data beat.
- mailbox, out, 128, current mailbox contents. DW0 is the command code.
- cmd_valid, out, 1, level: a new command is pending.
- cmd_ack, in, 1, command engine has consumed the command.
- cmd_cnt, out, 16, accepted commands, wraps.
- drop_cnt, out, 16, dropped TLPs, saturating.

Behaviour:
- Reset values (reset or init): rx_ack=0, rx_ws=0, mailbox=0, cmd_valid=0, cmd_cnt=0, drop_cnt=0, FSM in IDLE. reset is asynchronous; init is sampled on clk_in.
- Descriptor decode:
  - addr = fmt[0] ? desc[63:0] : {32'h0, desc[63:32]}.
  - dw_idx = addr[3:2]; len = desc[105:96].
  - The TLP is accepted only if all of the following hold: desc[128+BAR_IDX]=1, fmt[1]=1 (write), type=5'b00000, addr[OFS_WIDTH-1:4]==MAILBOX_OFS[OFS_WIDTH-1:4], 1<=len<=4, and dw_idx+len<=4.
  - Otherwise the TLP is a drop.
- FSM states: IDLE, ACK, DATA, COMMIT, DROP.
  - IDLE: on rx_req=1, latch the descriptor and go to ACK.
  - ACK: rx_ack=1 for exactly one cycle. Go to DATA if accepted; otherwise go to DROP if rx_dfr=1, else back to IDLE with drop_cnt+1.
  - DATA:
    - rx_ws=1 while cmd_valid=1 and cmd_ack=0, i.e. no merge while a command is pending.
    - A beat is taken on rx_dv=1 and rx_ws=0.
    - On the taken beat, each mailbox byte b in DW range [dw_idx, dw_idx+len-1] is written when rx_be[b]=1.
    - Go to COMMIT.
  - COMMIT (1 cycle): if the write covered DW0, set cmd_valid=1 and increment cmd_cnt. Return to IDLE.
  - DROP: rx_ws=0. Discard beats until rx_dfr=0 and rx_dv=0, then increment drop_cnt and return to IDLE.
- Latency: the first rx_data beat is merged into mailbox on the next edge. cmd_valid rises 2 cycles after the accepted beat.
- Handshake:
  - cmd_valid clears the cycle after cmd_ack=1.
  - If cmd_ack and a COMMIT setting cmd_valid occur in the same cycle, cmd_valid stays 1 (set wins) and cmd_cnt increments.
  - Writes that do not touch DW0 update the mailbox silently.
- Arithmetic:
  - drop_cnt saturates at 16'hFFFF.
  - cmd_cnt wraps modulo 2^16.
  - The length field is 10 bits; a value of 0 (1024 DW) counts as out of range and is dropped.
- Boundaries:
  - rx_req held high across back-to-back TLPs is taken once per pass through IDLE.
  - A multi-beat TLP (len>4) goes to DROP and consumes all of its beats.
  - reset or init mid-DATA discards the partial TLP. The mailbox is cleared and no cmd_valid is raised.

Test Plan:
- 4DW MWr, BAR0, addr 64'h1_0000_0100, len 4, rx_be=16'hFFFF, data 128'hDEAD...0001 -> rx_ack one pulse, mailbox=data, cmd_valid=1 two cycles after the beat, cmd_cnt=1.
- 3DW MWr, addr 32'h108 (dw_idx 2), len 2 -> mailbox[127:64] updated only, cmd_valid stays 0, cmd_cnt unchanged.
- While cmd_valid=1, a second 4DW MWr is sent -> rx_ws=1 until cmd_ack. The merge happens on the cycle after cmd_ack, cmd_valid is re-raised and cmd_cnt=2.
- MWr to addr 0x200, or a read TLP (fmt[1]=0), or len 8 over 2 beats -> rx_ack pulses, beats consumed, mailbox unchanged, drop_cnt +1 each. Force drop_cnt to 16'hFFFF and drop once more -> drop_cnt stays 16'hFFFF.
- len 1 at dw_idx 0 with rx_be=16'h000F and data 32'h0000_0007 -> mailbox[31:0]=7, other bytes retained, cmd_valid=1.
- reset asserted during DATA -> all outputs return to reset values at once. A subsequent valid TLP is processed normally.
